// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3, one input bit per clock.
// Handles unsigned or two's-complement operands; reports sign, digit count and overflow.
module bin_to_bcd_seq #(
    parameter  int WIDTH  = 400,
    parameter  int DIGITS = 121,
    localparam int CNT_W  = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_bin,
    input  logic                  in_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_neg,
    output logic [CNT_W-1:0]      out_ndigits,
    output logic                  out_ovf
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t               state_reg;
    state_t               state_next;

    logic [WIDTH-1:0]     mag_reg;
    logic [4*DIGITS-1:0]  bcd_reg;
    logic                 ovf_reg;
    logic [IW-1:0]        cnt_reg;
    logic                 neg_reg;
    logic [CNT_W-1:0]     ndigits_reg;
    logic                 out_ovf_reg;

    logic                 in_neg;
    logic [WIDTH-1:0]     in_mag;
    logic [4*DIGITS-1:0]  adj;
    logic [4*DIGITS-1:0]  bcd_shifted;
    logic                 top_carry;
    logic [DIGITS-1:0]    digit_nz;
    logic [CNT_W-1:0]     ndigits_next;

    assign in_neg = in_signed & in_bin[WIDTH-1];
    assign in_mag = in_neg ? (~in_bin + WIDTH'(1)) : in_bin;

    // Per-digit correction: any digit >= 5 gets +3 before the shift so it carries as decimal.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] digit;
            assign digit              = bcd_reg[4*gi +: 4];
            assign adj[4*gi +: 4]     = (digit >= 4'd5) ? digit + 4'd3 : digit;
            assign digit_nz[gi]       = |digit;
        end
    endgenerate

    // The bit leaving the top digit is a decimal carry beyond DIGITS digits.
    assign bcd_shifted = {adj[4*DIGITS-2:0], mag_reg[WIDTH-1]};
    assign top_carry   = adj[4*DIGITS-1];

    always_comb begin
        ndigits_next = CNT_W'(1);
        for (int k = 0; k < DIGITS; k++) begin
            if (digit_nz[k]) begin
                ndigits_next = CNT_W'(k + 1);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)        state_next = SHIFT;
            SHIFT:   if (cnt_reg == '0)   state_next = FINISH;
            FINISH:                       state_next = HOLD;
            HOLD:    if (out_ready)       state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_reg)
            IDLE:    in_ready  = 1'b1;
            HOLD:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_reg     <= '0;
            bcd_reg     <= '0;
            ovf_reg     <= 1'b0;
            cnt_reg     <= '0;
            neg_reg     <= 1'b0;
            ndigits_reg <= '0;
            out_ovf_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        mag_reg <= in_mag;
                        neg_reg <= in_neg;
                        bcd_reg <= '0;
                        ovf_reg <= 1'b0;
                        cnt_reg <= IW'(WIDTH - 1);
                    end
                end
                SHIFT: begin
                    mag_reg <= {mag_reg[WIDTH-2:0], 1'b0};
                    bcd_reg <= bcd_shifted;
                    ovf_reg <= ovf_reg | top_carry;
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - IW'(1);
                    end
                end
                FINISH: begin
                    ndigits_reg <= ndigits_next;
                    out_ovf_reg <= ovf_reg;
                end
                default: ;
            endcase
        end
    end

    assign out_bcd     = bcd_reg;
    assign out_neg     = neg_reg;
    assign out_ndigits = ndigits_reg;
    assign out_ovf     = out_ovf_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: 16-bit/5-digit and 16-bit/4-digit builds in lockstep,
// plus the 400-bit default build with random operands against a decimal reference model.
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Small builds share inputs
    logic        s_valid, s_signed, s_out_ready;
    logic [15:0] s_bin;
    logic        s_ready5, s_ovalid5, s_neg5, s_ovf5;
    logic [19:0] s_bcd5;
    logic [2:0]  s_nd5;
    logic        s_ready4, s_ovalid4, s_neg4, s_ovf4;
    logic [15:0] s_bcd4;
    logic [2:0]  s_nd4;

    // Default build
    logic         b_valid, b_signed, b_out_ready;
    logic [399:0] b_bin;
    logic         b_ready, b_ovalid, b_neg, b_ovf;
    logic [483:0] b_bcd;
    logic [6:0]   b_nd;

    int n_checks = 0;
    int n_pass   = 0;

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_ready5), .in_bin(s_bin),
        .in_signed(s_signed), .out_valid(s_ovalid5), .out_ready(s_out_ready), .out_bcd(s_bcd5),
        .out_neg(s_neg5), .out_ndigits(s_nd5), .out_ovf(s_ovf5)
    );

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_ready4), .in_bin(s_bin),
        .in_signed(s_signed), .out_valid(s_ovalid4), .out_ready(s_out_ready), .out_bcd(s_bcd4),
        .out_neg(s_neg4), .out_ndigits(s_nd4), .out_ovf(s_ovf4)
    );

    bin_to_bcd_seq dutb (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_bin(b_bin),
        .in_signed(b_signed), .out_valid(b_ovalid), .out_ready(b_out_ready), .out_bcd(b_bcd),
        .out_neg(b_neg), .out_ndigits(b_nd), .out_ovf(b_ovf)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Decimal reference: signed magnitude, then repeated division by ten.
    function automatic void ref_conv(input logic [399:0] v, input int w, input bit sgn, input int nd,
                                     output logic [483:0] bcd, output bit neg, output int ndig,
                                     output bit ovf);
        logic [400:0] m;
        logic [400:0] d;
        neg = sgn && v[w-1];
        m = {1'b0, v};
        if (neg) m = (401'd1 << w) - m;
        bcd  = '0;
        ndig = 1;
        for (int k = 0; k < nd; k++) begin
            d = m % 401'd10;
            bcd[4*k +: 4] = d[3:0];
            if (d != 0) ndig = k + 1;
            m = m / 401'd10;
        end
        ovf = (m != 0);
    endfunction

    task automatic run_small(input logic [15:0] b, input bit sg, input int hold);
        logic [483:0] e5, e4;
        bit n5, n4, o5, o4;
        int d5, d4, lat;
        logic [19:0] held_bcd;
        ref_conv({384'd0, b}, 16, sg, 5, e5, n5, d5, o5);
        ref_conv({384'd0, b}, 16, sg, 4, e4, n4, d4, o4);
        @(negedge clk);
        s_valid = 1'b1; s_bin = b; s_signed = sg; s_out_ready = 1'b0;
        check("in_ready_idle", s_ready5, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        lat = 0;
        while (!s_ovalid5 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 17);
        check("bcd5", s_bcd5, e5[19:0]);
        check("neg5", s_neg5, n5);
        check("ndigits5", s_nd5, d5);
        check("ovf5", s_ovf5, o5);
        check("bcd4", s_bcd4, e4[15:0]);
        check("ovf4", s_ovf4, o4);
        check("ndigits4", s_nd4, d4);
        held_bcd = s_bcd5;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            s_valid = 1'b1; s_bin = 16'($urandom); s_signed = 1'($urandom);
            @(posedge clk); #1;
            check("hold_valid", s_ovalid5, 1);
            check("hold_bcd", s_bcd5, held_bcd);
            check("hold_in_ready", s_ready5, 0);
        end
        @(negedge clk);
        s_valid = 1'b0; s_out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", s_ready5, 1);
        check("release_out_valid", s_ovalid5, 0);
        @(negedge clk);
        s_out_ready = 1'b0;
        $display("small: in=%h signed=%0d -> bcd5=%h nd=%0d neg=%0d | bcd4=%h ovf4=%0d lat=%0d",
                 b, sg, held_bcd, d5, n5, s_bcd4, o4, lat);
    endtask

    task automatic run_big(input logic [399:0] v, input bit sg);
        logic [483:0] e;
        bit n, o;
        int d, lat;
        ref_conv(v, 400, sg, 121, e, n, d, o);
        @(negedge clk);
        b_valid = 1'b1; b_bin = v; b_signed = sg; b_out_ready = 1'b0;
        @(posedge clk); #1;
        b_valid = 1'b0;
        lat = 0;
        while (!b_ovalid && lat < 1000) begin
            @(posedge clk); #1;
            lat++;
        end
        check("big_latency", lat, 401);
        check("big_bcd", b_bcd, e);
        check("big_neg", b_neg, n);
        check("big_ndigits", b_nd, d);
        check("big_ovf", b_ovf, o);
        @(negedge clk);
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        check("big_release", b_ready, 1);
        @(negedge clk);
        b_out_ready = 1'b0;
        $display("big: signed=%0d neg=%0d ndigits=%0d ovf=%0d lat=%0d", sg, n, d, o, lat);
    endtask

    initial begin
        logic [415:0] r;
        rst = 1'b1;
        s_valid = 0; s_signed = 0; s_out_ready = 0; s_bin = '0;
        b_valid = 0; b_signed = 0; b_out_ready = 0; b_bin = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", s_ready5, 1);
        check("rst_out_valid", s_ovalid5, 0);
        check("rst_bcd", s_bcd5, 0);
        check("rst_neg", s_neg5, 0);
        check("rst_ndigits", s_nd5, 0);
        check("rst_ovf", s_ovf5, 0);
        check("rst_big_in_ready", b_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        run_small(16'hFFFF, 1'b0, 0);
        run_small(16'h8000, 1'b1, 0);
        run_small(16'hFFFF, 1'b1, 0);
        run_small(16'h0000, 1'b1, 0);
        run_small(16'h0000, 1'b0, 0);
        run_small(16'd100,  1'b0, 0);
        run_small(16'd9999, 1'b0, 0);
        run_small(16'd4321, 1'b1, 10);
        for (int i = 0; i < 8; i++) run_small(16'($urandom), 1'($urandom), 0);

        // Abort a conversion part-way through with reset
        @(negedge clk);
        s_valid = 1'b1; s_bin = 16'd54321; s_signed = 1'b0;
        @(posedge clk); #1;
        s_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready", s_ready5, 1);
        check("abort_out_valid", s_ovalid5, 0);
        check("abort_bcd", s_bcd5, 0);
        check("abort_neg", s_neg5, 0);
        check("abort_ndigits", s_nd5, 0);
        check("abort_ovf", s_ovf5, 0);
        @(negedge clk);
        rst = 1'b0;
        $display("reset abort: in_ready=%0d out_valid=%0d", s_ready5, s_ovalid5);
        run_small(16'd12345, 1'b0, 0);

        run_big('0, 1'b1);
        run_big({1'b1, 399'd0}, 1'b1);
        run_big({400{1'b1}}, 1'b0);
        run_big({400{1'b1}}, 1'b1);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 13; j++) r[32*j +: 32] = $urandom;
            run_big(r[399:0], 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
